pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the fetch stage. Replaces the free-running
//  +4 counter. Adds reset vector, stall, branch/jump redirect, trap entry,
//  misaligned-target fault and a return-address stack (RAS) for call/return.
//  Drives instruction-memory address and the pc+INC value used by the writeback path.
// PARAMETERS
//  XLEN         32  PC width in bits
//  RESET_VECTOR 0   PC value loaded on reset; low ALIGN_BITS bits must be 0
//  INC          4   sequential increment in bytes
//  ALIGN_BITS   2   number of low target bits that must be zero
//  RAS_DEPTH    4   return-address stack entries, >=2
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous reset, active-high
//  stall_i        in   1     hold PC; also blocks redirect/push/pop (trap not blocked)
//  redirect_i     in   1     taken branch/jump
//  redirect_tgt_i in   XLEN  redirect target
//  push_i         in   1     call: push pc_o+INC onto RAS
//  pop_i          in   1     return: PC <= RAS top
//  trap_i         in   1     trap entry, highest priority
//  trap_vec_i     in   XLEN  trap handler address; low ALIGN_BITS bits forced to 0
//  pc_o           out  XLEN  current fetch address (registered)
//  pc_inc_o       out  XLEN  pc_o+INC, combinational, mod 2^XLEN
//  fetch_valid_o  out  1     pc_o is a valid fetch address
//  fault_o        out  1     in FAULT state (misaligned redirect taken)
//  ras_ovf_o      out  1     one-cycle pulse: push on full RAS
//  ras_unf_o      out  1     one-cycle pulse: pop on empty RAS
//  ras_count_o    out  $clog2(RAS_DEPTH+1)  RAS occupancy
// BEHAVIOUR
//  Reset (async, rst=1): pc_o=RESET_VECTOR, state=BOOT, fetch_valid_o=0, fault_o=0,
//   ras_count_o=0, pulses=0. RAS contents don't-care.
//  States: BOOT -> RUN on first clk edge with rst=0 (pc_o unchanged on that edge).
//   RUN -> FAULT on misaligned redirect. FAULT -> RUN only via trap_i.
//  fetch_valid_o=1 only in RUN. fault_o=1 only in FAULT; FAULT holds pc_o.
//  RUN, per edge, priority order:
//   1 trap_i: pc<=trap_vec_i & ~((1<<ALIGN_BITS)-1); ignores stall; RAS untouched.
//   2 stall_i: pc, RAS, state held; redirect/push/pop ignored, no pulses.
//   3 redirect_i & tgt low bits !=0: pc held, state<=FAULT, push/pop ignored.
//   4 redirect_i: pc<=redirect_tgt_i; push_i honoured (pushes old pc_o+INC); pop_i ignored.
//   5 pop_i & count>0: pc<=RAS top; with push_i top replaced by pc_o+INC, count same.
//   6 pop_i & count==0: ras_unf_o pulse; pc<=pc_o+INC; push_i (if set) still pushes.
//   7 otherwise pc<=pc_o+INC; push_i pushes pc_o+INC.
//  RAS: circular, top pointer mod RAS_DEPTH. Push on full overwrites oldest entry,
//   count saturates at RAS_DEPTH, ras_ovf_o pulses. Pulses last exactly one cycle.
//  FAULT/BOOT: only trap_i acts (FAULT) ; all other inputs ignored.
//  Arithmetic mod 2^XLEN: pc 2^XLEN-INC + INC wraps to 0, no flag.
//  rst mid-operation: immediate return to reset values regardless of state.
// TESTING
//  rst 1->0, 3 free edges -> pc_o 0,0,4,8; fetch_valid_o 0,1,1,1 from 2nd edge.
//  pc=0x10, stall_i=1 + redirect to 0x40 for 2 edges -> pc stays 0x10; release -> 0x14.
//  pc=0x20 push+redirect 0x100; then pop -> pc 0x100 then 0x24; count 1 then 0.
//  RAS_DEPTH=4, 5 pushes -> ras_ovf_o pulses once, count=4; 5 pops -> last pops
//   return newest 4 addrs, 5th gives ras_unf_o pulse and pc+4.
//  redirect to 0x102 -> pc held, fault_o=1, fetch_valid_o=0; trap_vec 0x203 -> pc 0x200, RUN.
//  pc=0xFFFF_FFFC, one free edge -> pc_o 0x0000_0000; assert rst mid-RAS use -> count 0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage. It supports a reset vector, stall,
// branch/jump redirect, trap entry, a misaligned-target fault state, and a
// circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall_i,
  input  logic                             redirect_i,
  input  logic [XLEN-1:0]                  redirect_tgt_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic                             trap_i,
  input  logic [XLEN-1:0]                  trap_vec_i,
  output logic [XLEN-1:0]                  pc_o,
  output logic [XLEN-1:0]                  pc_inc_o,
  output logic                             fetch_valid_o,
  output logic                             fault_o,
  output logic                             ras_ovf_o,
  output logic                             ras_unf_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [XLEN-1:0]   ras_q [RAS_DEPTH];

  logic              ras_we;
  logic [PTR_W-1:0]  ras_widx;
  logic [XLEN-1:0]   ras_wdata;
  logic              do_push;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   trap_tgt;
  logic              tgt_misaligned;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;

  assign pc_inc         = pc_q + XLEN'(INC);
  assign trap_tgt       = trap_vec_i & ~ALIGN_MASK;
  assign tgt_misaligned = |(redirect_tgt_i & ALIGN_MASK);
  assign ptr_inc        = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign ptr_dec        = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

  // State and datapath registers; async reset returns everything to boot values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // RAS storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_widx] <= ras_wdata;
  end

  // Next-state logic: boot lasts one edge, misaligned redirect faults, trap recovers
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (!trap_i && !stall_i && redirect_i && tgt_misaligned) state_d = ST_FAULT;
      ST_FAULT: if (trap_i) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Datapath control: PC selection by priority and RAS push/pop bookkeeping
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    ras_we    = 1'b0;
    ras_widx  = top_q;
    ras_wdata = pc_inc;
    do_push   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (trap_i) begin
          pc_d = trap_tgt;
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (redirect_i && tgt_misaligned) begin
          pc_d = pc_q;
        end else if (redirect_i) begin
          pc_d    = redirect_tgt_i;
          do_push = push_i;
        end else if (pop_i && (cnt_q != '0)) begin
          pc_d = ras_q[top_q];
          if (push_i) begin
            // Call in the same cycle as return: replace top in place
            ras_we = 1'b1;
          end else begin
            top_d = ptr_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          pc_d    = pc_inc;
          unf_d   = pop_i;
          do_push = push_i;
        end
      end
      ST_FAULT: if (trap_i) pc_d = trap_tgt;
      default:  pc_d = pc_q;
    endcase
    // A push on a full stack overwrites the oldest entry and saturates the count
    if (do_push) begin
      ras_we   = 1'b1;
      ras_widx = ptr_inc;
      top_d    = ptr_inc;
      if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
      else                            cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode from registered state
  always_comb begin
    fetch_valid_o = (state_q == ST_RUN);
    fault_o       = (state_q == ST_FAULT);
    pc_o          = pc_q;
    pc_inc_o      = pc_inc;
    ras_ovf_o     = ovf_q;
    ras_unf_o     = unf_q;
    ras_count_o   = cnt_q;
  end

endmodule
